dccm_arbiter: RTL

Two-port arbiter that shares the single-ported DFFRAM data memory (DCCM) between two SRAM-style requesters, e.g. the TL-UL SRAM adapter (port A) and a second data master (port B). Per cycle it grants at most one request, using round-robin with a bounded burst allowance. It converts the bit write mask into DFFRAM byte write enables and routes the one-cycle-latency read data back to the requester that issued the read. It sits directly between the requesters' req/gnt interfaces and the DFFRAM EN/WE/DI/DO/A pins.

---
 rtl/dccm_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dccm_arbiter.sv
// dccm_arbiter: shares one single-ported DFFRAM between two SRAM-style
// requesters. The arbiter grants at most one access per cycle. It uses
// round-robin with a bounded burst allowance. Bit write masks become byte
// enables, and one-cycle read data is steered back to the issuing port.
module dccm_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MaxBurst = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_req_i,
  output logic            a_gnt_o,
  input  logic            a_we_i,
  input  logic [AW-1:0]   a_addr_i,
  input  logic [DW-1:0]   a_wdata_i,
  input  logic [DW-1:0]   a_wmask_i,
  output logic [DW-1:0]   a_rdata_o,
  output logic            a_rvalid_o,
  input  logic            b_req_i,
  output logic            b_gnt_o,
  input  logic            b_we_i,
  input  logic [AW-1:0]   b_addr_i,
  input  logic [DW-1:0]   b_wdata_i,
  input  logic [DW-1:0]   b_wmask_i,
  output logic [DW-1:0]   b_rdata_o,
  output logic            b_rvalid_o,
  output logic            mem_en_o,
  output logic [DW/8-1:0] mem_we_o,
  output logic [DW-1:0]   mem_di_o,
  output logic [AW-1:0]   mem_a_o,
  input  logic [DW-1:0]   mem_do_i
);

  localparam int CW = $clog2(MaxBurst + 1);
  localparam int NB = DW / 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(MaxBurst);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  owner_t          owner_q, owner_next, gnt_owner;
  logic [CW-1:0]   cnt_q, cnt_next;
  logic            rd_a_q, rd_b_q;
  logic            gnt_a, gnt_b;
  logic            sel_we;
  logic [DW-1:0]   sel_wmask;

  // Grant decision: the owner keeps the memory while its burst allowance
  // lasts, and a lone requester is always served. Nothing is granted in reset.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst_i) begin
      if (a_req_i && b_req_i) begin
        if (cnt_q < CNT_MAX) begin
          gnt_a = (owner_q == OWN_A);
          gnt_b = (owner_q == OWN_B);
        end else begin
          gnt_a = (owner_q == OWN_B);
          gnt_b = (owner_q == OWN_A);
        end
      end else begin
        gnt_a = a_req_i;
        gnt_b = b_req_i;
      end
    end
  end

  // Next owner/burst count. An idle cycle clears the burst but keeps the owner.
  // If the owner is granted again, its count saturates. A new owner starts at 1.
  always_comb begin
    owner_next = owner_q;
    cnt_next   = cnt_q;
    gnt_owner  = gnt_b ? OWN_B : OWN_A;
    if (!gnt_a && !gnt_b) begin
      cnt_next = '0;
    end else if (gnt_owner == owner_q) begin
      cnt_next = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end else begin
      owner_next = gnt_owner;
      cnt_next   = CNT_ONE;
    end
  end

  // Arbitration state and read-return flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_A;
      cnt_q   <= '0;
      rd_a_q  <= 1'b0;
      rd_b_q  <= 1'b0;
    end else begin
      owner_q <= owner_next;
      cnt_q   <= cnt_next;
      rd_a_q  <= gnt_a && !a_we_i;
      rd_b_q  <= gnt_b && !b_we_i;
    end
  end

  assign a_gnt_o  = gnt_a;
  assign b_gnt_o  = gnt_b;
  assign mem_en_o = gnt_a | gnt_b;

  // Port A drives the address and data buses unless B holds the grant.
  assign mem_a_o   = gnt_b ? b_addr_i  : a_addr_i;
  assign mem_di_o  = gnt_b ? b_wdata_i : a_wdata_i;
  assign sel_wmask = gnt_b ? b_wmask_i : a_wmask_i;
  assign sel_we    = (gnt_a && a_we_i) || (gnt_b && b_we_i);

  // A byte is written when any of its mask bits is set.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte_we
      assign mem_we_o[gi] = sel_we && (|sel_wmask[8*gi +: 8]);
    end
  endgenerate

  // Read data goes to both ports, and only the issuer's rvalid rises. The
  // rvalid is masked while reset is asserted. A read granted just before
  // reset therefore never shows a response.
  assign a_rdata_o  = mem_do_i;
  assign b_rdata_o  = mem_do_i;
  assign a_rvalid_o = rd_a_q && !rst_i;
  assign b_rvalid_o = rd_b_q && !rst_i;

endmodule
